// File: rtl/monitor_report_pkg.sv
// Shared types and helpers for the monitor report collector.
package monitor_report_pkg;

  localparam int NUM_REPORTS_DEFAULT = 40;
  localparam int IDX_W_DEFAULT       = 32;
  localparam int REPORT_ID_W         = 6;
  localparam int VEC_MAX             = 1 << REPORT_ID_W;

  typedef enum logic {IDLE, SCAN} state_e;

  typedef struct packed {
    logic [REPORT_ID_W-1:0]   id;
    logic [IDX_W_DEFAULT-1:0] idx;
  } report_rec_t;

  // Priority pick of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [REPORT_ID_W-1:0] lowest_set_bit(input logic [VEC_MAX-1:0] vec);
    lowest_set_bit = '0;
    for (int i = VEC_MAX - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_bit = REPORT_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/report_vec_fifo.sv
// Synchronous FIFO for captured report vectors; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module report_vec_fifo #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == COUNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/monitor_report_collector.sv
// Collects non-zero report vectors with their symbol index and serialises them
// into one record per set bit. Optional drop counter: MONITOR_REPORT_DROP_CNT_EN.
module monitor_report_collector
  import monitor_report_pkg::*;
#(
  parameter int NUM_REPORTS = NUM_REPORTS_DEFAULT,
  parameter int IDX_W       = IDX_W_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_bits,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [REPORT_ID_W-1:0] rec_id,
  output logic [IDX_W-1:0]       rec_idx,
  output logic                   overflow,
  output logic                   busy
`ifdef MONITOR_REPORT_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int FIFO_W = NUM_REPORTS + IDX_W;

  state_e                 state, state_n;
  logic [IDX_W-1:0]       sym_idx;
  logic                   capture;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FIFO_W-1:0]      fifo_dout;
  logic                   drop;
  logic [NUM_REPORTS-1:0] work_bits;
  logic [NUM_REPORTS-1:0] work_bits_clr;
  logic [IDX_W-1:0]       work_idx;
  logic [REPORT_ID_W-1:0] cur_id;
  logic                   handshake;
  report_rec_t            rec;

  assign capture  = run && (report_bits != '0);
  assign fifo_pop = (state == IDLE) && !fifo_empty;
  assign drop     = capture && fifo_full && !fifo_pop;

  report_vec_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (fifo_pop),
    .din   ({report_bits, sym_idx}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)    sym_idx <= '0;
    else if (run) sym_idx <= sym_idx + 1'b1;
  end

  assign cur_id        = lowest_set_bit(VEC_MAX'(work_bits));
  assign work_bits_clr = work_bits & ~(NUM_REPORTS'(1) << cur_id);
  assign handshake     = (state == SCAN) && rec_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!fifo_empty) state_n = SCAN;
      SCAN:    if (rec_ready && (work_bits_clr == '0)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Work register is datapath only; state gates its visibility.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      work_bits <= fifo_dout[FIFO_W-1:IDX_W];
      work_idx  <= fifo_dout[IDX_W-1:0];
    end else if (handshake) begin
      work_bits <= work_bits_clr;
    end
  end

  always_comb begin
    rec     = '0;
    rec.id  = cur_id;
    rec.idx = IDX_W_DEFAULT'(work_idx);
  end

  assign rec_valid = (state == SCAN);
  assign rec_id    = rec_valid ? rec.id : '0;
  assign rec_idx   = rec_valid ? IDX_W'(rec.idx) : '0;
  assign busy      = !fifo_empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef MONITOR_REPORT_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                            drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_monitor_report_collector.sv
// Randomised and directed bench for monitor_report_collector against a
// queue-based reference model.
module tb_monitor_report_collector;

  localparam int NR    = 40;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic [NR-1:0] report_bits = '0;
  logic          rec_ready = 1'b0;
  logic          rec_valid;
  logic [5:0]    rec_id;
  logic [IW-1:0] rec_idx;
  logic          overflow;
  logic          busy;
`ifdef MONITOR_REPORT_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  logic          run_w = 1'b0;
  logic [NR-1:0] bits_w = '0;
  logic          ready_w = 1'b1;
  logic          valid_w;
  logic [5:0]    id_w;
  logic [3:0]    idx_w;
  logic          ovf_w;
  logic          busy_w;
`ifdef MONITOR_REPORT_DROP_CNT_EN
  logic [15:0]   drop_cnt_w;
`endif

  always #5 clk = ~clk;

  monitor_report_collector #(.NUM_REPORTS(NR), .IDX_W(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run), .report_bits(report_bits),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id), .rec_idx(rec_idx),
    .overflow(overflow), .busy(busy)
`ifdef MONITOR_REPORT_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  monitor_report_collector #(.NUM_REPORTS(NR), .IDX_W(4), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset(reset), .run(run_w), .report_bits(bits_w),
    .rec_valid(valid_w), .rec_ready(ready_w), .rec_id(id_w), .rec_idx(idx_w),
    .overflow(ovf_w), .busy(busy_w)
`ifdef MONITOR_REPORT_DROP_CNT_EN
    , .drop_cnt(drop_cnt_w)
`endif
  );

  typedef struct {
    logic [NR-1:0] bits;
    logic [IW-1:0] idx;
  } vec_t;

  typedef struct {
    int            id;
    logic [IW-1:0] idx;
  } rec_t;

  vec_t          q[$];
  rec_t          obs[$];
  logic [NR-1:0] m_work;
  logic [IW-1:0] m_widx;
  bit            m_active;
  logic [IW-1:0] m_cnt;
  bit            m_ovf;
  int            m_drops;
  bit            just_reset;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int low_bit(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input bit rst, input bit r, input logic [NR-1:0] b, input bit rdy);
    bit hs, pop;
    if (rst) begin
      q.delete(); obs.delete();
      m_active = 0; m_cnt = '0; m_ovf = 0; m_drops = 0; just_reset = 1;
      return;
    end
    just_reset = 0;
    hs  = m_active && rdy;
    pop = !m_active && (q.size() > 0);
    if (hs) begin
      m_work[low_bit(m_work)] = 1'b0;
      if (m_work == '0) m_active = 0;
    end
    if (pop) begin
      m_work = q[0].bits; m_widx = q[0].idx; void'(q.pop_front()); m_active = 1;
    end
    if (r && b != '0) begin
      if (q.size() < DEPTH) q.push_back('{b, m_cnt});
      else begin m_ovf = 1; m_drops++; end
    end
    if (r) m_cnt = m_cnt + 1;
  endtask

  task automatic compare_outputs();
    check("rec_valid", 64'(rec_valid), 64'(m_active));
    check("busy", 64'(busy), 64'(m_active || q.size() > 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (m_active) begin
      check("rec_id", 64'(rec_id), 64'(low_bit(m_work)));
      check("rec_idx", 64'(rec_idx), 64'(m_widx));
    end else if (just_reset) begin
      check("rst_rec_id", 64'(rec_id), 64'd0);
      check("rst_rec_idx", 64'(rec_idx), 64'd0);
    end
`ifdef MONITOR_REPORT_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'((m_drops > 65535) ? 65535 : m_drops));
`endif
  endtask

  task automatic cycle(input bit rst, input bit r, input logic [NR-1:0] b, input bit rdy);
    reset = rst; run = r; report_bits = b; rec_ready = rdy;
    if (!rst && rec_valid && rdy) obs.push_back('{int'(rec_id), rec_idx});
    @(posedge clk);
    model_edge(rst, r, b, rdy);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    cycle(1, 1, 40'h1, 1);
    reset = 0;
  endtask

  function automatic logic [NR-1:0] rand_vec();
    logic [63:0] a;
    a = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
    if (a[NR-1:0] == '0) a[$urandom_range(NR-1, 0)] = 1'b1;
    return a[NR-1:0];
  endfunction

  task automatic drain(input int limit);
    int n = 0;
    while (busy && n < limit) begin cycle(0, 0, '0, 1); n++; end
    check("drain_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [NR-1:0] v;
    // Latency and index after idle run cycles
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, '0, 1);
    v = '0; v[5] = 1'b1;
    cycle(0, 1, v, 1);
    check("lat_capture_valid", 64'(rec_valid), 64'd0);
    cycle(0, 0, '0, 1);
    check("lat_valid", 64'(rec_valid), 64'd1);
    check("lat_id", 64'(rec_id), 64'd5);
    check("lat_idx", 64'(rec_idx), 64'd3);
    cycle(0, 0, '0, 1);
    check("single_record", 64'(rec_valid), 64'd0);

    // Multi-bit vector with stall
    do_reset();
    cycle(0, 1, '0, 0);
    v = '0; v[0] = 1'b1; v[7] = 1'b1; v[39] = 1'b1;
    cycle(0, 1, v, 0);
    cycle(0, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      check("stall_id", 64'(rec_id), 64'd0);
      check("stall_idx", 64'(rec_idx), 64'd1);
      cycle(0, 0, '0, 0);
    end
    cycle(0, 0, '0, 1);
    check("seq_id7", 64'(rec_id), 64'd7);
    check("seq_idx7", 64'(rec_idx), 64'd1);
    cycle(0, 0, '0, 1);
    check("seq_id39", 64'(rec_id), 64'd39);
    cycle(0, 0, '0, 1);
    check("seq_done", 64'(rec_valid), 64'd0);

    // Overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 1, rand_vec(), 0);
    check("ovf_set", 64'(overflow), 64'd1);
`ifdef MONITOR_REPORT_DROP_CNT_EN
    check("drop_cnt_one", 64'(drop_cnt), 64'd1);
`endif
    drain(400);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // run toggling
    do_reset();
    cycle(0, 1, 40'h4, 1);
    cycle(0, 0, 40'h8, 1);
    cycle(0, 1, 40'h10, 1);
    drain(50);
    check("toggle_count", 64'(obs.size()), 64'd2);
    if (obs.size() == 2) begin
      check("toggle_id0", 64'(obs[0].id), 64'd2);
      check("toggle_idx0", 64'(obs[0].idx), 64'd0);
      check("toggle_id1", 64'(obs[1].id), 64'd4);
      check("toggle_idx1", 64'(obs[1].idx), 64'd1);
    end

    // Counter wrap on a 4-bit index instance
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_w = 1'b1;
      bits_w = '0;
      if (i == 16) bits_w[3] = 1'b1;
      cycle(0, 0, '0, 1);
    end
    run_w = 1'b0; bits_w = '0;
    cycle(0, 0, '0, 1);
    check("wrap_valid", 64'(valid_w), 64'd1);
    check("wrap_id", 64'(id_w), 64'd3);
    check("wrap_idx", 64'(idx_w), 64'd0);
    cycle(0, 0, '0, 1);

    // Reset mid-SCAN
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 1, rand_vec(), 0);
    cycle(1, 1, rand_vec(), 1);
    reset = 0;
    check("rst_mid_valid", 64'(rec_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1);
    check("rst_no_stale", 64'(obs.size()), 64'd0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle(0, ($urandom % 4) != 0, (($urandom % 3) == 0) ? rand_vec() : '0, ($urandom % 3) != 0);
    drain(1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
